// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and defaults for alu_mc
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Bit 4 set marks an M-extension op.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_PASS2  = 5'd10,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// rtl/alu_mc_mdu_iter.sv - iterative multiply/divide datapath, built only under ALU_MC_MDU_EN
`ifdef ALU_MC_MDU_EN
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic              active_q, active_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d, hi_q, hi_d, rem_q, rem_d;
    logic              neg_q, neg_d, nrem_q, nrem_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [2*XLEN-1:0] p_q, p_d;

    logic              is_div, sa, sb, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b, hi, lo, diff, q, r;
    logic [XLEN:0]     sum, shifted;
    logic [2*XLEN-1:0] p_step, full;

    always_comb begin
        is_div = op[2];
        sa     = is_div ? ~op[0] : (op != OP_MULHU);
        sb     = is_div ? ~op[0] : (op == OP_MUL || op == OP_MULH);
        neg_a  = sa & opa[XLEN-1];
        neg_b  = sb & opb[XLEN-1];
        abs_a  = neg_a ? -opa : opa;
        abs_b  = neg_b ? -opb : opb;

        // Multiply: shift-add into the high half. Divide: restoring step, P = {rem, quotient}.
        hi      = p_q[2*XLEN-1:XLEN];
        lo      = p_q[XLEN-1:0];
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_q} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted[XLEN-1:0] - mag_q;
        if (!div_q)
            p_step = {sum, lo[XLEN-1:1]};
        else if (shifted >= {1'b0, mag_q})
            p_step = {diff, lo[XLEN-2:0], 1'b1};
        else
            p_step = {p_q[2*XLEN-2:0], 1'b0};

        full   = neg_q ? -p_step : p_step;
        q      = p_step[XLEN-1:0];
        r      = p_step[2*XLEN-1:XLEN];
        if (div_q)
            result = rem_q ? (nrem_q ? -r : r) : (neg_q ? -q : q);
        else
            result = hi_q ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];

        done = active_q && (cnt_q == CW'(XLEN - 1));

        active_d = active_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        nrem_d   = nrem_q;
        mag_d    = mag_q;
        p_d      = p_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            div_d    = is_div;
            hi_d     = (op != OP_MUL);
            rem_d    = op[1];
            neg_d    = neg_a ^ neg_b;
            nrem_d   = neg_a;
            mag_d    = is_div ? abs_b : abs_a;
            p_d      = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
        end else if (active_q) begin
            p_d   = p_step;
            cnt_d = cnt_q + CW'(1);
            if (done)
                active_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            nrem_q   <= 1'b0;
            mag_q    <= '0;
            p_q      <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            nrem_q   <= nrem_d;
            mag_q    <= mag_d;
            p_q      <= p_d;
        end
    end

endmodule
`endif

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU top; M ops built only when ALU_MC_MDU_EN is defined
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);
    alu_state_t      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            base_ill;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid && in_ready;
    assign shamt     = operand2[SHW-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (op)
            OP_ADD:   base_res = operand1 + operand2;
            OP_SUB:   base_res = operand1 - operand2;
            OP_SLL:   base_res = operand1 << shamt;
            OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, operand1 < operand2};
            OP_XOR:   base_res = operand1 ^ operand2;
            OP_SRL:   base_res = operand1 >> shamt;
            OP_SRA:   base_res = $unsigned($signed(operand1) >>> shamt);
            OP_OR:    base_res = operand1 | operand2;
            OP_AND:   base_res = operand1 & operand2;
            OP_PASS2: base_res = operand2;
            default:  base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MDU_EN
    logic            is_m, div0, ovf, mdu_start, mdu_done;
    logic [XLEN-1:0] special_res, mdu_result;

    // Divide-by-zero and signed overflow bypass the iterator entirely.
    assign is_m        = op[4] & ~op[3];
    assign div0        = (operand2 == '0);
    assign ovf         = ~op[0] && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (&operand2);
    assign special_res = op[1] ? (div0 ? operand1 : '0) : (div0 ? '1 : operand1);
    assign busy        = (state_q == ST_ITER);

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (op),
        .opa    (operand1),
        .opb    (operand2),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MC_MDU_EN
        mdu_start = 1'b0;
`endif
        if (state_q == ST_DONE && out_ready)
            state_d = ST_IDLE;
        if (accept) begin
            state_d   = ST_DONE;
            result_d  = base_res;
            illegal_d = base_ill;
`ifdef ALU_MC_MDU_EN
            if (is_m) begin
                illegal_d = 1'b0;
                if (op[2] && (div0 || ovf)) begin
                    result_d = special_res;
                end else begin
                    mdu_start = 1'b1;
                    state_d   = ST_ITER;
                end
            end
`endif
        end
`ifdef ALU_MC_MDU_EN
        if (state_q == ST_ITER && mdu_done) begin
            state_d   = ST_DONE;
            result_d  = mdu_result;
            illegal_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc; M-op expectations follow ALU_MC_MDU_EN
module tb_alu_mc;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, out_valid, out_ready, illegal, busy;
    logic [4:0]      op;
    logic [XLEN-1:0] operand1, operand2, result;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, sp;
        logic [63:0] up;
        logic [31:0] r;
        logic        ill;
        logic        ovf;
        r   = '0;
        ill = 1'b0;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sp  = '0;
        up  = '0;
        case (o)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_SLL:   r = a << b[4:0];
            OP_SLT:   r = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU:  r = {31'd0, a < b};
            OP_XOR:   r = a ^ b;
            OP_SRL:   r = a >> b[4:0];
            OP_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_PASS2: r = b;
`ifdef ALU_MC_MDU_EN
            OP_MUL:    begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            OP_MULH:   begin sp = sa * sbv; r = sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed({32'd0, b}); r = sp[63:32]; end
            OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $unsigned($signed(a) / $signed(b));
            OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    r = (b == 0) ? a : ovf ? 32'd0 : $unsigned($signed(a) % $signed(b));
            OP_REMU:   r = (b == 0) ? a : a % b;
`endif
            default:  ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MC_MDU_EN
        if (o[4] && !o[3]) begin
            if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                return 1;
            return XLEN + 1;
        end
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] e;
        int          n, lat;
        bit          busy_ok;
        lat = exp_lat(o, a, b);
        sb_q.push_back(model(o, a, b));
        chk({tag, " in_ready"}, 64'(in_ready), 64'(1));
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        operand1 = ~a;
        n        = 1;
        busy_ok  = 1'b1;
        while (!out_valid && n < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        if (lat > 1) chk({tag, " busy"}, 64'(busy_ok), 64'(1));
        e = sb_q.pop_front();
        chk({tag, " result"}, 64'(result), 64'(e[31:0]));
        chk({tag, " illegal"}, 64'(illegal), 64'(e[32]));
        @(posedge clk); #1;
        chk({tag, " retire"}, 64'(out_valid), 64'(0));
    endtask

    logic [4:0]  s_op[5] = '{OP_SRA, OP_SLT, OP_SLTU, OP_SLL, OP_SRL};
    logic [31:0] s_a[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000};
    logic [31:0] s_b[5]  = '{32'd31, 32'd1, 32'd1, 32'd33, 32'd33};

    initial begin
        logic [32:0] e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; operand1 = '0; operand2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst in_ready", 64'(in_ready), 64'(1));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst result", 64'(result), 64'(0));
        chk("rst illegal", 64'(illegal), 64'(0));

        run_op("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h1);
        chk("add_wrap const", 64'(model(OP_ADD, 32'h7FFF_FFFF, 32'h1)), 64'h0_8000_0000);

        // Back-to-back stream: each edge retires one result and accepts the next.
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(model(s_op[i], s_a[i], s_b[i]));
            op = s_op[i]; operand1 = s_a[i]; operand2 = s_b[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            e = sb_q.pop_front();
            chk($sformatf("stream%0d valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("stream%0d result", i), 64'(result), 64'(e[31:0]));
            chk($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream drain", 64'(out_valid), 64'(0));

        sb_q.push_back(model(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000));
        op = OP_XOR; operand1 = 32'hA5A5_A5A5; operand2 = 32'hFFFF_0000;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        e = sb_q.pop_front();
        op = OP_OR; operand1 = 32'h0F0F_0000; operand2 = 32'h0000_00FF;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d result", i), 64'(result), 64'(e[31:0]));
            chk($sformatf("hold%0d in_ready", i), 64'(in_ready), 64'(0));
            chk($sformatf("hold%0d valid", i), 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        sb_q.push_back(model(OP_OR, 32'h0F0F_0000, 32'h0000_00FF));
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb_q.pop_front();
        chk("nobubble valid", 64'(out_valid), 64'(1));
        chk("nobubble result", 64'(result), 64'(e[31:0]));
        @(posedge clk); #1;

        run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h2);
        run_op("mul", OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'h2);
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'h2);
        run_op("divu", OP_DIVU, 32'd100, 32'd7);
        run_op("remu", OP_REMU, 32'd100, 32'd7);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
        run_op("rem_by0", OP_REM, 32'd5, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("op12", 5'd12, 32'd3, 32'd4);
        run_op("op31", 5'd31, 32'd3, 32'd4);

        // Reset while the multiply is iterating (or holding in DONE when M ops are absent).
        op = OP_MUL; operand1 = 32'd3; operand2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort valid", 64'(out_valid), 64'(0));
        chk("abort in_ready", 64'(in_ready), 64'(1));
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort result", 64'(result), 64'(0));
        run_op("post_rst_add", OP_ADD, 32'd5, 32'd6);
        chk("scoreboard empty", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
